// File: rtl/alu_bitserial_ctrl.sv
// rtl/alu_bitserial_ctrl.sv - bit-serial N-bit ALU sequencer driving one 1-bit ALU slice

// One-bit ALU slice: 00 NOR, 01 XOR, 10 ADD, 11 SUB (b inverted, borrow-free carry)
module alu1bit (
   input  logic       a,
   input  logic       b,
   input  logic       cin,
   input  logic [1:0] op,
   output logic       s,
   output logic       cout
);

   logic b_eff;

   // Sum/logic output and full-adder carry; carry is meaningless for NOR/XOR
   always_comb begin
      b_eff = (op == 2'b11) ? ~b : b;
      s     = 1'b0;
      case (op)
         2'b00:   s = ~(a | b);
         2'b01:   s = a ^ b;
         default: s = a ^ b_eff ^ cin;
      endcase
      cout = (a & b_eff) | (a & cin) | (b_eff & cin);
   end

endmodule

// Sequencer: shifts operands LSB first through the slice and assembles the result
module alu_bitserial_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   op,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         ovf
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   sa_q, sa_d;
   logic [N-1:0]   sb_q, sb_d;
   logic [N-1:0]   res_sh_q, res_sh_d;
   logic           carry_q, carry_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     op_q, op_d;
   logic [N-1:0]   result_q, result_d;
   logic           cout_q, cout_d;
   logic           ovf_q, ovf_d;

   logic           slice_s;
   logic           slice_cout;
   logic           accept;
   logic           arith;

   alu1bit u_slice (
      .a    (sa_q[0]),
      .b    (sb_q[0]),
      .cin  (carry_q),
      .op   (op_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   assign busy   = (state_q == S_RUN);
   assign done   = (state_q == S_DONE);
   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

   // Next-state logic: bit stepping in RUN, operand capture on an accepted start
   always_comb begin
      state_d  = state_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      arith    = op_q[1];
      accept   = start && (state_q != S_RUN);

      case (state_q)
         S_RUN: begin
            res_sh_d = {slice_s, res_sh_q[N-1:1]};
            sa_d     = sa_q >> 1;
            sb_d     = sb_q >> 1;
            carry_d  = slice_cout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Final bit: carry_q is the carry into the MSB, slice_cout the carry out
               state_d  = S_DONE;
               cnt_d    = '0;
               result_d = {slice_s, res_sh_q[N-1:1]};
               cout_d   = arith & slice_cout;
               ovf_d    = arith & (carry_q ^ slice_cout);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Start is honoured in IDLE and DONE alike, which gives back-to-back operation
      if (accept) begin
         state_d = S_RUN;
         sa_d    = a;
         sb_d    = b;
         op_d    = op;
         cnt_d   = '0;
         carry_d = (op == 2'b11);
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sa_q     <= '0;
         sb_q     <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         op_q     <= 2'b00;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule

// File: tb/tb_alu_bitserial_ctrl.sv
// tb/tb_alu_bitserial_ctrl.sv - directed self-checking bench for alu_bitserial_ctrl
module tb_alu_bitserial_ctrl;

   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [N-1:0] a_i;
   logic [N-1:0] b_i;
   logic [1:0]   op_i;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         cout;
   logic         ovf;

   int total;
   int bad;

   alu_bitserial_ctrl #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a_i),
      .b      (b_i),
      .op     (op_i),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Called at a negedge; returns at the negedge of the done cycle (or after timeout)
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] opv,
                        output int lat, output int busy_n, output logic [7:0] res_first,
                        output bit timed_out);
      a_i = av; b_i = bv; op_i = opv; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      res_first = result;
      lat = 1;
      busy_n = 0;
      while (!done && lat < 40) begin
         if (busy) busy_n++;
         @(negedge clk);
         lat++;
      end
      timed_out = !done;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; op_i = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({busy, done, result, cout, ovf} !== 12'h000) begin
         bad++;
         $display("FAIL reset_state got=%h want=000", {busy, done, result, cout, ovf});
      end
   endtask

   task automatic test_add_basic();
      int lat, bn; logic [7:0] rf; bit to;
      @(negedge clk);
      do_op(8'h5A, 8'h3C, 2'b10, lat, bn, rf, to);
      total++;
      if (to || lat != N + 1) begin bad++; $display("FAIL add_latency got=%0d want=%0d", lat, N + 1); end
      total++;
      if (bn != N) begin bad++; $display("FAIL add_busy_cycles got=%0d want=%0d", bn, N); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_in_done got=%b want=0", busy); end
      total++;
      if ({result, cout, ovf} !== {8'h96, 1'b0, 1'b1})
         begin bad++; $display("FAIL add_5a_3c got=%h/%b/%b want=96/0/1", result, cout, ovf); end
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
   endtask

   task automatic test_arith_vectors();
      logic [7:0] va   [7] = '{8'h10, 8'h80, 8'h00, 8'hFF, 8'h7F, 8'hF0, 8'hA5};
      logic [7:0] vb   [7] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0C, 8'hFF};
      logic [1:0] vop  [7] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01};
      logic [7:0] vres [7] = '{8'h0F, 8'h7F, 8'hFF, 8'h00, 8'h80, 8'h03, 8'h5A};
      logic       vc   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       vo   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat, bn; logic [7:0] rf; bit to;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         do_op(va[i], vb[i], vop[i], lat, bn, rf, to);
         total++;
         if (to || {result, cout, ovf} !== {vres[i], vc[i], vo[i]}) begin
            bad++;
            $display("FAIL vec%0d op=%b a=%h b=%h got=%h/%b/%b want=%h/%b/%b timeout=%0d",
                     i, vop[i], va[i], vb[i], result, cout, ovf, vres[i], vc[i], vo[i], to);
         end
      end
   endtask

   task automatic test_start_held();
      int lat;
      @(negedge clk);
      a_i = 8'h11; b_i = 8'h22; op_i = 2'b10; start = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         a_i = 8'hFF - a_i; b_i = b_i + 8'h35; op_i = op_i + 2'd1;
      end while (!done && lat < 40);
      start = 1'b0;
      total++;
      if (!done || lat != N + 1 || result !== 8'h33 || cout !== 1'b0)
         begin bad++; $display("FAIL start_held got=%h lat=%0d want=33 lat=%0d", result, lat, N + 1); end
   endtask

   task automatic test_back_to_back();
      int lat, bn; logic [7:0] rf; bit to;
      @(negedge clk);
      @(negedge clk);
      do_op(8'hC8, 8'h64, 2'b10, lat, bn, rf, to);
      total++;
      if (to || {result, cout, ovf} !== {8'h2C, 1'b1, 1'b0})
         begin bad++; $display("FAIL b2b_first got=%h/%b/%b want=2c/1/0", result, cout, ovf); end
      do_op(8'h01, 8'h02, 2'b10, lat, bn, rf, to);
      total++;
      if (rf !== 8'h2C) begin bad++; $display("FAIL result_hold_run got=%h want=2c", rf); end
      total++;
      if (to || lat != N + 1 || bn != N)
         begin bad++; $display("FAIL b2b_timing got lat=%0d busy=%0d want lat=%0d busy=%0d", lat, bn, N + 1, N); end
      total++;
      if ({result, cout, ovf} !== {8'h03, 1'b0, 1'b0})
         begin bad++; $display("FAIL b2b_second got=%h/%b/%b want=03/0/0", result, cout, ovf); end
   endtask

   task automatic test_reset_mid_run();
      int seen; int lat, bn; logic [7:0] rf; bit to;
      @(negedge clk);
      a_i = 8'h5A; b_i = 8'h3C; op_i = 2'b10; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({busy, result, cout, ovf} !== 11'h000)
         begin bad++; $display("FAIL rst_mid got busy=%b res=%h want busy=0 res=00", busy, result); end
      seen = 0;
      repeat (15) begin
         if (done) seen++;
         @(negedge clk);
      end
      total++;
      if (seen != 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", seen); end
      do_op(8'h01, 8'h01, 2'b10, lat, bn, rf, to);
      total++;
      if (to || result !== 8'h02) begin bad++; $display("FAIL after_rst got=%h want=02", result); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_add_basic();
      test_arith_vectors();
      test_start_held();
      test_back_to_back();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
